// File: rtl/motor_plant_array_if.sv
// Bus between the drone testbench and the motor plant array.
// FAULT_INJECT_EN adds a per-channel fault_mask driven by the master.
interface motor_plant_array_if #(
  parameter int unsigned NUM_MOTORS = 4,
  parameter int unsigned RPM_W      = 16
);
  logic                        set;
  logic [NUM_MOTORS*RPM_W-1:0] rpm_set;
  logic [NUM_MOTORS*RPM_W-1:0] mot_cmd;
  logic [NUM_MOTORS*RPM_W-1:0] rpm_sense;
  logic [NUM_MOTORS-1:0]       settled;
`ifdef FAULT_INJECT_EN
  logic [NUM_MOTORS-1:0]       fault_mask;
`endif

  modport master (
    output set, rpm_set, mot_cmd,
`ifdef FAULT_INJECT_EN
    output fault_mask,
`endif
    input  rpm_sense, settled
  );

  modport slave (
    input  set, rpm_set, mot_cmd,
`ifdef FAULT_INJECT_EN
    input  fault_mask,
`endif
    output rpm_sense, settled
  );
endinterface

// File: rtl/motor_plant_array.sv
// N-channel motor plant: turns each commanded rpm into a slew-limited,
// spin-up-delayed sensed rpm. Optional feature macro: FAULT_INJECT_EN
// (masked channels ignore their command and decay to a stop).
module motor_plant_array #(
  parameter int unsigned NUM_MOTORS    = 4,
  parameter int unsigned RPM_W         = 16,
  parameter int unsigned SLEW_STEP     = 8,
  parameter int unsigned UPDATE_DIV    = 4,
  parameter int unsigned SPINUP_CYCLES = 16,
  parameter int unsigned SETTLE_TOL    = 8
) (
  input logic                  clk,
  input logic                  resetn,
  motor_plant_array_if.slave   bus
);
  localparam int unsigned PreW  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int unsigned SpinW = (SPINUP_CYCLES > 1) ? $clog2(SPINUP_CYCLES) : 1;
  localparam logic [RPM_W:0] SlewX = (RPM_W+1)'(SLEW_STEP);
  localparam logic [RPM_W:0] TolX  = (RPM_W+1)'(SETTLE_TOL);
  localparam logic [RPM_W:0] OneX  = (RPM_W+1)'(1);

  typedef enum logic [1:0] {StStopped, StSpinup, StTrack} state_e;

  state_e             state_q [NUM_MOTORS];
  state_e             state_d [NUM_MOTORS];
  logic [SpinW-1:0]   spin_q  [NUM_MOTORS];
  logic [SpinW-1:0]   spin_d  [NUM_MOTORS];
  logic [RPM_W-1:0]   sense_q [NUM_MOTORS];
  logic [RPM_W-1:0]   sense_d [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] settled_q, settled_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic               tick;

  logic [NUM_MOTORS-1:0] masked;
  logic [RPM_W-1:0]   cmd_eff [NUM_MOTORS];
  logic [RPM_W:0]     err     [NUM_MOTORS];
  logic [RPM_W:0]     mag     [NUM_MOTORS];
  logic [RPM_W:0]     step    [NUM_MOTORS];
  logic [RPM_W:0]     upd_x   [NUM_MOTORS];

  // Shared prescaler; a set restarts it and swallows any coincident tick.
  always_comb begin
    tick  = (pre_q == PreW'(UPDATE_DIV - 1));
    pre_d = (bus.set || tick) ? '0 : pre_q + PreW'(1);
  end

  // Per-channel error and slew-limited update, in RPM_W+1 bits so no wrap.
  always_comb begin
    for (int i = 0; i < NUM_MOTORS; i++) begin
`ifdef FAULT_INJECT_EN
      masked[i] = bus.fault_mask[i];
`else
      masked[i] = 1'b0;
`endif
      // A masked channel behaves as if commanded to stop.
      cmd_eff[i] = masked[i] ? '0 : bus.mot_cmd[i*RPM_W +: RPM_W];
      err[i]   = {cmd_eff[i][RPM_W-1], cmd_eff[i]} - {sense_q[i][RPM_W-1], sense_q[i]};
      mag[i]   = err[i][RPM_W] ? (~err[i] + OneX) : err[i];
      step[i]  = (mag[i] > SlewX) ? SlewX : mag[i];
      upd_x[i] = err[i][RPM_W] ? ({sense_q[i][RPM_W-1], sense_q[i]} - step[i])
                               : ({sense_q[i][RPM_W-1], sense_q[i]} + step[i]);
    end
  end

  // Next-state logic per channel; set overrides everything.
  always_comb begin
    for (int i = 0; i < NUM_MOTORS; i++) begin
      state_d[i] = state_q[i];
      spin_d[i]  = spin_q[i];
      sense_d[i] = sense_q[i];
      if (bus.set) begin
        sense_d[i] = bus.rpm_set[i*RPM_W +: RPM_W];
        state_d[i] = (bus.rpm_set[i*RPM_W +: RPM_W] != '0) ? StTrack : StStopped;
        spin_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          StStopped: begin
            sense_d[i] = '0;
            if (cmd_eff[i] != '0) begin
              state_d[i] = StSpinup;
              spin_d[i]  = '0;
            end
          end
          StSpinup: begin
            sense_d[i] = '0;
            spin_d[i]  = spin_q[i] + SpinW'(1);
            if (cmd_eff[i] == '0) begin
              state_d[i] = StStopped;
              spin_d[i]  = '0;
            end else if (spin_q[i] == SpinW'(SPINUP_CYCLES - 1)) begin
              state_d[i] = StTrack;
              spin_d[i]  = '0;
            end
          end
          StTrack: begin
            if (tick) begin
              sense_d[i] = upd_x[i][RPM_W-1:0];
              if (upd_x[i][RPM_W-1:0] == '0) state_d[i] = StStopped;
            end
          end
          default: begin
            state_d[i] = StStopped;
            sense_d[i] = '0;
            spin_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Settled flag (registered) and output packing straight from registers.
  always_comb begin
    bus.rpm_sense = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      settled_d[i] = !masked[i] &&
                     (((state_q[i] == StTrack) && (mag[i] <= TolX)) ||
                      ((state_q[i] == StStopped) && (cmd_eff[i] == '0)));
      bus.rpm_sense[i*RPM_W +: RPM_W] = sense_q[i];
    end
    bus.settled = settled_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q     <= '0;
      settled_q <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        state_q[i] <= StStopped;
        spin_q[i]  <= '0;
        sense_q[i] <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      settled_q <= settled_d;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        state_q[i] <= state_d[i];
        spin_q[i]  <= spin_d[i];
        sense_q[i] <= sense_d[i];
      end
    end
  end
endmodule

// File: tb/tb_motor_plant_array.sv
// Self-checking bench for motor_plant_array against a cycle-level model.
module tb_motor_plant_array;
  localparam int NM = 4;
  localparam int W = 16;
  localparam int SLEW = 8;
  localparam int DIV = 4;
  localparam int SPIN = 16;
  localparam int TOL = 8;
  localparam int MD_STOP = 0;
  localparam int MD_SPIN = 1;
  localparam int MD_TRACK = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  motor_plant_array_if bus ();
  motor_plant_array dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  logic signed [W-1:0] cmd_a [NM];
  logic signed [W-1:0] pre_a [NM];
  logic                set_r;
  logic [NM-1:0]       mask_a;

  always_comb begin
    bus.mot_cmd = '0;
    bus.rpm_set = '0;
    for (int i = 0; i < NM; i++) begin
      bus.mot_cmd[i*W +: W] = cmd_a[i];
      bus.rpm_set[i*W +: W] = pre_a[i];
    end
    bus.set = set_r;
`ifdef FAULT_INJECT_EN
    bus.fault_mask = mask_a;
`endif
  end

  int vecs = 0;
  int errs = 0;

  // Model: sensed rpm, mode, cycles spent spinning up, settled flag, phase.
  int m_sense [NM];
  int m_mode  [NM];
  int m_elap  [NM];
  bit m_settled [NM];
  int m_phase;

  function automatic void model_reset();
    for (int c = 0; c < NM; c++) begin
      m_sense[c] = 0; m_mode[c] = MD_STOP; m_elap[c] = 0; m_settled[c] = 0;
    end
    m_phase = 0;
  endfunction

  function automatic logic [NM*W-1:0] exp_sense();
    logic [NM*W-1:0] r;
    for (int c = 0; c < NM; c++) r[c*W +: W] = W'(m_sense[c]);
    return r;
  endfunction

  function automatic logic [NM-1:0] exp_settled();
    logic [NM-1:0] r;
    for (int c = 0; c < NM; c++) r[c] = m_settled[c];
    return r;
  endfunction

  // Advance one clock: evaluate the model on the pre-edge inputs, then commit.
  task automatic clk_step();
    int n_sense [NM];
    int n_mode  [NM];
    int n_elap  [NM];
    bit n_set   [NM];
    int n_phase;
    bit tick;
    int cmd, err, mag, stp;
    tick = (m_phase == DIV - 1);
    n_phase = (set_r || tick) ? 0 : m_phase + 1;
    for (int c = 0; c < NM; c++) begin
      cmd = mask_a[c] ? 0 : int'(cmd_a[c]);
      err = cmd - m_sense[c];
      mag = (err < 0) ? -err : err;
      n_set[c] = !mask_a[c] && ((m_mode[c] == MD_TRACK && mag <= TOL) ||
                                (m_mode[c] == MD_STOP && cmd == 0));
      n_sense[c] = m_sense[c]; n_mode[c] = m_mode[c]; n_elap[c] = m_elap[c];
      if (set_r) begin
        n_sense[c] = int'(pre_a[c]);
        n_mode[c]  = (pre_a[c] != 0) ? MD_TRACK : MD_STOP;
        n_elap[c]  = 0;
      end else if (m_mode[c] == MD_STOP) begin
        if (cmd != 0) begin n_mode[c] = MD_SPIN; n_elap[c] = 0; end
      end else if (m_mode[c] == MD_SPIN) begin
        if (cmd == 0) n_mode[c] = MD_STOP;
        else if (m_elap[c] + 1 == SPIN) n_mode[c] = MD_TRACK;
        else n_elap[c] = m_elap[c] + 1;
      end else if (tick) begin
        stp = (mag > SLEW) ? SLEW : mag;
        n_sense[c] = m_sense[c] + ((err < 0) ? -stp : stp);
        if (n_sense[c] == 0) n_mode[c] = MD_STOP;
      end
    end
    @(posedge clk);
    #1;
    if (!resetn) begin
      model_reset();
    end else begin
      for (int c = 0; c < NM; c++) begin
        m_sense[c] = n_sense[c]; m_mode[c] = n_mode[c];
        m_elap[c] = n_elap[c]; m_settled[c] = n_set[c];
      end
      m_phase = n_phase;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < NM; c++) begin cmd_a[c] = 0; pre_a[c] = 0; end
    set_r = 0; mask_a = '0; resetn = 0;
    model_reset();
    #12;
    vecs++;
    if (bus.rpm_sense !== '0 || bus.settled !== '0) begin
      $display("FAIL reset_hold: sense=%h settled=%b want 0/0", bus.rpm_sense, bus.settled);
      errs++;
    end
    @(posedge clk); #1;
    resetn = 1;
    clk_step();
    vecs++;
    if (bus.settled !== 4'hF || bus.rpm_sense !== '0) begin
      $display("FAIL reset_release: settled=%b sense=%h want 1111/0", bus.settled, bus.rpm_sense);
      errs++;
    end
  endtask

  task automatic test_spinup();
    cmd_a[0] = 100;
    for (int k = 0; k < 80; k++) begin
      clk_step();
      if (k < 17) begin
        vecs++;
        if (bus.rpm_sense[W-1:0] !== 16'd0) begin
          $display("FAIL spinup_dead k=%0d: got %0d want 0", k, bus.rpm_sense[W-1:0]);
          errs++;
        end
      end
      vecs++;
      if (bus.rpm_sense !== exp_sense() || bus.settled !== exp_settled()) begin
        $display("FAIL spinup k=%0d: sense=%h settled=%b want %h %b", k, bus.rpm_sense,
                 bus.settled, exp_sense(), exp_settled());
        errs++;
      end
    end
    vecs++;
    if (bus.rpm_sense[W-1:0] !== 16'd100 || bus.settled[0] !== 1'b1) begin
      $display("FAIL spinup_final: sense0=%0d settled0=%b want 100/1", bus.rpm_sense[W-1:0],
               bus.settled[0]);
      errs++;
    end
  endtask

  task automatic test_reversal();
    pre_a[0] = 100; pre_a[1] = 0; pre_a[2] = 40; pre_a[3] = 0;
    cmd_a[2] = -40;
    set_r = 1;
    clk_step();
    set_r = 0;
    for (int k = 0; k < 90; k++) begin
      clk_step();
      vecs++;
      if (bus.rpm_sense !== exp_sense() || bus.settled !== exp_settled()) begin
        $display("FAIL reversal k=%0d: sense=%h settled=%b want %h %b", k, bus.rpm_sense,
                 bus.settled, exp_sense(), exp_settled());
        errs++;
      end
    end
    vecs++;
    if (bus.rpm_sense[2*W +: W] !== 16'hFFD8) begin
      $display("FAIL reversal_final: sense2=%h want ffd8", bus.rpm_sense[2*W +: W]);
      errs++;
    end
  endtask

  task automatic test_extremes();
    bit seen = 0;
    for (int c = 0; c < NM; c++) pre_a[c] = W'(m_sense[c]);
    pre_a[3] = -32768;
    cmd_a[3] = 32767;
    set_r = 1;
    clk_step();
    set_r = 0;
    for (int k = 0; k < 33000 && m_sense[3] != 32767; k++) begin
      clk_step();
      if (!seen && m_sense[3] != -32768) begin
        seen = 1;
        vecs++;
        if (bus.rpm_sense[3*W +: W] !== 16'h8008) begin
          $display("FAIL extreme_first: sense3=%h want 8008", bus.rpm_sense[3*W +: W]);
          errs++;
        end
      end
      vecs++;
      if (bus.rpm_sense !== exp_sense() || bus.settled !== exp_settled()) begin
        $display("FAIL extreme k=%0d: sense=%h settled=%b want %h %b", k, bus.rpm_sense,
                 bus.settled, exp_sense(), exp_settled());
        errs++;
      end
    end
    clk_step();
    vecs++;
    if (bus.rpm_sense[3*W +: W] !== 16'h7FFF) begin
      $display("FAIL extreme_final: sense3=%h want 7fff", bus.rpm_sense[3*W +: W]);
      errs++;
    end
  endtask

  task automatic test_set_midspin();
    cmd_a[1] = 50;
    for (int k = 0; k < 6; k++) clk_step();
    for (int c = 0; c < NM; c++) pre_a[c] = W'(m_sense[c]);
    pre_a[1] = 500;
    set_r = 1;
    clk_step();
    set_r = 0;
    vecs++;
    if (bus.rpm_sense[W +: W] !== 16'd500) begin
      $display("FAIL set_midspin: sense1=%0d want 500", bus.rpm_sense[W +: W]);
      errs++;
    end
    for (int k = 0; k < 30; k++) begin
      clk_step();
      vecs++;
      if (bus.rpm_sense !== exp_sense() || bus.settled !== exp_settled()) begin
        $display("FAIL after_set k=%0d: sense=%h settled=%b want %h %b", k, bus.rpm_sense,
                 bus.settled, exp_sense(), exp_settled());
        errs++;
      end
    end
    resetn = 0;
    #1;
    model_reset();
    vecs++;
    if (bus.rpm_sense !== '0 || bus.settled !== '0) begin
      $display("FAIL async_reset: sense=%h settled=%b want 0/0", bus.rpm_sense, bus.settled);
      errs++;
    end
    clk_step();
    resetn = 1;
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 3000; k++) begin
      set_r = 0;
      for (int c = 0; c < NM; c++) begin
        r = $urandom_range(0, 15);
        if (r == 0) cmd_a[c] = 0;
        else if (r == 1) cmd_a[c] = W'($urandom_range(0, 200) - 100);
        else if (r == 2) cmd_a[c] = W'($urandom);
      end
      if ($urandom_range(0, 63) == 0) begin
        set_r = 1;
        for (int c = 0; c < NM; c++)
          pre_a[c] = ($urandom_range(0, 2) == 0) ? 16'sd0 : W'($urandom_range(0, 400) - 200);
      end
      if ($urandom_range(0, 999) == 0) resetn = 0;
      else resetn = 1;
      clk_step();
      vecs++;
      if (bus.rpm_sense !== exp_sense() || bus.settled !== exp_settled()) begin
        $display("FAIL random k=%0d: sense=%h settled=%b want %h %b", k, bus.rpm_sense,
                 bus.settled, exp_sense(), exp_settled());
        errs++;
      end
    end
    set_r = 0;
    resetn = 1;
  endtask

`ifdef FAULT_INJECT_EN
  task automatic test_fault();
    for (int c = 0; c < NM; c++) pre_a[c] = W'(m_sense[c]);
    pre_a[0] = 200;
    cmd_a[0] = 200;
    mask_a = 4'b0001;
    set_r = 1;
    clk_step();
    set_r = 0;
    for (int k = 0; k < 150; k++) begin
      clk_step();
      vecs++;
      if (bus.rpm_sense !== exp_sense() || bus.settled !== exp_settled()) begin
        $display("FAIL fault k=%0d: sense=%h settled=%b want %h %b", k, bus.rpm_sense,
                 bus.settled, exp_sense(), exp_settled());
        errs++;
      end
    end
    vecs++;
    if (bus.rpm_sense[W-1:0] !== 16'd0 || bus.settled[0] !== 1'b0) begin
      $display("FAIL fault_final: sense0=%0d settled0=%b want 0/0", bus.rpm_sense[W-1:0],
               bus.settled[0]);
      errs++;
    end
    mask_a = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_spinup();
    test_reversal();
    test_extremes();
    test_set_midspin();
`ifdef FAULT_INJECT_EN
    test_fault();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
